// File: rtl/egd_bitstream_aligner_pkg.sv
// +----------------------------------------------------------------------+
// | egd_pkg: shared widths and types for the exp-Golomb front end.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package egd_pkg;
  localparam int EGD_WIN_W  = 16;
  localparam int EGD_WORD_W = 16;
  localparam int EGD_LEN_W  = 5;
  localparam int EGD_BUF_W  = 48;
  localparam int EGD_FILL_W = 6;

  typedef logic [EGD_WIN_W-1:0] egd_win_t;
endpackage

`default_nettype wire

// File: rtl/egd_bitstream_aligner_if.sv
// +----------------------------------------------------------------------+
// | egd_bitstream_aligner_if: stream-in and decoder-window bundle.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface egd_bitstream_aligner_if;
  import egd_pkg::*;

  logic [EGD_WORD_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  egd_win_t              win_data;
  logic                  win_valid;
  logic                  consume;
  logic [EGD_LEN_W-1:0]  consume_len;
  logic                  align;
  logic                  flush;
  logic [EGD_FILL_W-1:0] fill_level;
  logic [2:0]            bit_pos;
  logic                  err;

  // master = upstream source plus decoder; slave = the aligner itself
  modport master (
    output in_data, in_valid, consume, consume_len, align, flush,
    input  in_ready, win_data, win_valid, fill_level, bit_pos, err
  );

  modport slave (
    input  in_data, in_valid, consume, consume_len, align, flush,
    output in_ready, win_data, win_valid, fill_level, bit_pos, err
  );
endinterface

`default_nettype wire

// File: rtl/egd_bitstream_aligner_funnel_shift.sv
// +----------------------------------------------------------------------+
// | egd_funnel_shift: left shift of the buffer plus word insert at offset|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module egd_funnel_shift #(
  parameter int BUF_W  = 48,
  parameter int WORD_W = 16,
  parameter int SH_W   = 6
) (
  input  logic [BUF_W-1:0]  data_i,
  input  logic [SH_W-1:0]   shift_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              ins_i,
  input  logic [SH_W-1:0]   offset_i,
  output logic [BUF_W-1:0]  data_o
);
  logic [BUF_W-1:0] w_word_ext;
  logic [BUF_W-1:0] w_word_pos;

  assign w_word_ext = {{(BUF_W-WORD_W){1'b0}}, word_i};
  assign w_word_pos = ins_i ? (w_word_ext << offset_i) : '0;
  // Zero-fill from the right keeps bits below the fill level cleared.
  assign data_o     = (data_i << shift_i) | w_word_pos;
endmodule

`default_nettype wire

// File: rtl/egd_bitstream_aligner.sv
// +----------------------------------------------------------------------+
// | egd_bitstream_aligner: buffers MSB-first words, exposes a 16-bit     |
// | left-aligned window, retires 0..16 bits per cycle. Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module egd_bitstream_aligner
  import egd_pkg::*;
#(
  parameter int WORD_W = EGD_WORD_W,
  parameter int WIN_W  = EGD_WIN_W,
  parameter int BUF_W  = EGD_BUF_W
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  egd_bitstream_aligner_if.slave  bus
);
  localparam int FILL_W = EGD_FILL_W;
  localparam logic [FILL_W-1:0]    c_word_room = FILL_W'(BUF_W - WORD_W);
  localparam logic [FILL_W-1:0]    c_win_w     = FILL_W'(WIN_W);
  localparam logic [FILL_W-1:0]    c_word_w    = FILL_W'(WORD_W);
  localparam logic [EGD_LEN_W-1:0] c_max_len   = EGD_LEN_W'(WIN_W);

  logic [BUF_W-1:0]  shreg_q, shreg_d, w_shifted;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] w_retire, w_fill_rem, w_ins_off;
  logic [2:0]        bit_pos_q, bit_pos_d, w_align_n;
  logic              err_q, err_d;
  logic              w_in_ready, w_win_valid, w_xfer;

  assign w_in_ready  = (fill_q <= c_word_room);
  assign w_win_valid = (fill_q >= c_win_w);
  assign w_xfer      = bus.in_valid & w_in_ready;
  // (8 - bit_pos) % 8 is just the 3-bit two's complement of bit_pos
  assign w_align_n   = 3'd0 - bit_pos_q;

  always_comb begin
    w_retire = '0;
    err_d    = err_q;
    if (!bus.flush) begin
      if (bus.align) begin
        if (FILL_W'(w_align_n) <= fill_q) w_retire = FILL_W'(w_align_n);
        else                              err_d    = 1'b1;
      end else if (bus.consume && (bus.consume_len != '0)) begin
        if ((bus.consume_len <= c_max_len) &&
            (FILL_W'(bus.consume_len) <= fill_q) && w_win_valid)
          w_retire = FILL_W'(bus.consume_len);
        else
          err_d = 1'b1;
      end
    end
  end

  assign w_fill_rem = fill_q - w_retire;
  assign w_ins_off  = c_word_room - w_fill_rem;

  egd_funnel_shift #(
    .BUF_W  (BUF_W),
    .WORD_W (WORD_W),
    .SH_W   (FILL_W)
  ) u_funnel (
    .data_i   (shreg_q),
    .shift_i  (w_retire),
    .word_i   (bus.in_data),
    .ins_i    (w_xfer),
    .offset_i (w_ins_off),
    .data_o   (w_shifted)
  );

  always_comb begin
    shreg_d   = w_shifted;
    fill_d    = w_xfer ? (w_fill_rem + c_word_w) : w_fill_rem;
    bit_pos_d = bit_pos_q + w_retire[2:0];
    if (bus.flush) begin
      shreg_d   = '0;
      fill_d    = '0;
      bit_pos_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      fill_q    <= '0;
      bit_pos_q <= '0;
      err_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      fill_q    <= fill_d;
      bit_pos_q <= bit_pos_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.win_data   = shreg_q[BUF_W-1 -: WIN_W];
  assign bus.win_valid  = w_win_valid;
  assign bus.fill_level = fill_q;
  assign bus.bit_pos    = bit_pos_q;
  assign bus.err        = err_q;
endmodule

`default_nettype wire

// File: tb/tb_egd_bitstream_aligner.sv
// +----------------------------------------------------------------------+
// | tb_egd_bitstream_aligner: directed + random bench against a bit-queue|
// | reference model. Rev 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_egd_bitstream_aligner;
  import egd_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  egd_bitstream_aligner_if bus ();

  egd_bitstream_aligner dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: the buffered stream as a plain queue of bits, oldest first.
  bit mq[$];
  int mpos;
  bit merr;

  function automatic void model_reset();
    mq.delete();
    mpos = 0;
    merr = 1'b0;
  endfunction

  function automatic logic [15:0] m_win();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) if (i < mq.size()) w[15-i] = mq[i];
    return w;
  endfunction

  function automatic void model_step(bit fl, bit al, bit co, logic [4:0] len, bit v, logic [15:0] d);
    int n = 0;
    int a;
    bit rdy = (mq.size() <= 32);
    if (fl) begin
      mq.delete();
      mpos = 0;
      return;
    end
    if (al) begin
      a = (8 - mpos) % 8;
      if (a <= mq.size()) n = a;
      else merr = 1'b1;
    end else if (co && len != 0) begin
      if (len <= 16 && int'(len) <= mq.size() && mq.size() >= 16) n = int'(len);
      else merr = 1'b1;
    end
    repeat (n) void'(mq.pop_front());
    mpos = (mpos + n) % 8;
    if (v && rdy) for (int i = 15; i >= 0; i--) mq.push_back(d[i]);
  endfunction

  task automatic cycle(input bit fl, input bit al, input bit co, input int len, input bit v, input logic [15:0] d);
    bus.flush       = fl;
    bus.align       = al;
    bus.consume     = co;
    bus.consume_len = 5'(len);
    bus.in_valid    = v;
    bus.in_data     = d;
    model_step(fl, al, co, 5'(len), v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.flush = 0; bus.align = 0; bus.consume = 0; bus.consume_len = '0;
    bus.in_valid = 0; bus.in_data = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", bus.in_ready); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid actual=%b required=0", bus.win_valid); end
    checks++; if (bus.win_data !== 16'h0) begin failures++; $display("FAIL reset_win_data actual=%h required=0000", bus.win_data); end
    checks++; if (bus.fill_level !== 6'd0 || bus.bit_pos !== 3'd0 || bus.err !== 1'b0) begin
      failures++; $display("FAIL reset_state actual fill=%0d pos=%0d err=%b required 0/0/0", bus.fill_level, bus.bit_pos, bus.err); end
  endtask

  task automatic test_push();
    do_reset();
    cycle(0, 0, 0, 0, 1, 16'hA5C3);
    checks++; if (bus.win_data !== 16'hA5C3 || bus.win_valid !== 1'b1 || bus.fill_level !== 6'd16) begin
      failures++; $display("FAIL push1 actual win=%h wv=%b fill=%0d required A5C3/1/16", bus.win_data, bus.win_valid, bus.fill_level); end
    cycle(0, 0, 0, 0, 1, 16'h0F0F);
    checks++; if (bus.fill_level !== 6'd32) begin failures++; $display("FAIL push2_fill actual=%0d required=32", bus.fill_level); end
  endtask

  task automatic test_consume_align();
    cycle(0, 0, 1, 3, 0, 16'h0);
    checks++; if (bus.win_data !== 16'h2E18 || bus.fill_level !== 6'd29 || bus.bit_pos !== 3'd3) begin
      failures++; $display("FAIL consume3 actual win=%h fill=%0d pos=%0d required 2E18/29/3", bus.win_data, bus.fill_level, bus.bit_pos); end
    cycle(0, 0, 1, 0, 0, 16'h0);
    checks++; if (bus.win_data !== 16'h2E18 || bus.err !== 1'b0) begin
      failures++; $display("FAIL consume0 actual win=%h err=%b required 2E18/0", bus.win_data, bus.err); end
    cycle(0, 1, 1, 9, 0, 16'h0);
    checks++; if (bus.win_data !== 16'hC30F || bus.fill_level !== 6'd24 || bus.bit_pos !== 3'd0) begin
      failures++; $display("FAIL align actual win=%h fill=%0d pos=%0d required C30F/24/0", bus.win_data, bus.fill_level, bus.bit_pos); end
  endtask

  task automatic test_full();
    logic [15:0] w[4];
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, w[i]);
    checks++; if (bus.fill_level !== 6'd48 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL full actual fill=%0d rdy=%b required 48/0", bus.fill_level, bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 1, w[3]);
      checks++; if (bus.in_ready !== 1'b0 || bus.fill_level !== 6'd48 || bus.win_data !== w[0]) begin
        failures++; $display("FAIL full_hold%0d actual rdy=%b fill=%0d win=%h required 0/48/%h", k, bus.in_ready, bus.fill_level, bus.win_data, w[0]); end
    end
    cycle(0, 0, 1, 16, 1, w[3]);
    checks++; if (bus.in_ready !== 1'b1 || bus.fill_level !== 6'd32 || bus.win_data !== w[1]) begin
      failures++; $display("FAIL full_drain actual rdy=%b fill=%0d win=%h required 1/32/%h", bus.in_ready, bus.fill_level, bus.win_data, w[1]); end
    cycle(0, 0, 0, 0, 1, w[3]);
    checks++; if (bus.fill_level !== 6'd48) begin failures++; $display("FAIL full_accept actual=%0d required=48", bus.fill_level); end
    cycle(0, 0, 1, 16, 0, 16'h0);
    cycle(0, 0, 1, 16, 0, 16'h0);
    checks++; if (bus.win_data !== w[3] || bus.fill_level !== 6'd16) begin
      failures++; $display("FAIL full_held_word actual win=%h fill=%0d required %h/16", bus.win_data, bus.fill_level, w[3]); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] cat;
    logic [15:0] exp_w;
    do_reset();
    cat = {16'($urandom), 16'($urandom), 16'($urandom)};
    cycle(0, 0, 0, 0, 1, cat[47:32]);
    cycle(0, 0, 0, 0, 1, cat[31:16]);
    cycle(0, 0, 1, 12, 0, 16'h0);
    cycle(0, 0, 1, 7, 1, cat[15:0]);
    exp_w = cat[28:13];
    checks++; if (bus.fill_level !== 6'd29 || bus.win_data !== exp_w) begin
      failures++; $display("FAIL b2b actual fill=%0d win=%h required 29/%h", bus.fill_level, bus.win_data, exp_w); end
    cycle(0, 0, 1, 16, 0, 16'h0);
    exp_w = {cat[12:0], 3'b000};
    checks++; if (bus.fill_level !== 6'd13 || bus.win_data !== exp_w || bus.win_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_tail actual fill=%0d win=%h wv=%b required 13/%h/0", bus.fill_level, bus.win_data, bus.win_valid, exp_w); end
  endtask

  task automatic test_err();
    do_reset();
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 1, 11, 0, 16'h0);
    checks++; if (bus.err !== 1'b0 || bus.fill_level !== 6'd5) begin
      failures++; $display("FAIL err_pre actual err=%b fill=%0d required 0/5", bus.err, bus.fill_level); end
    cycle(0, 0, 1, 9, 0, 16'h0);
    checks++; if (bus.err !== 1'b1 || bus.fill_level !== 6'd5) begin
      failures++; $display("FAIL err_underrun actual err=%b fill=%0d required 1/5", bus.err, bus.fill_level); end
    do_reset();
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 1, 17, 0, 16'h0);
    checks++; if (bus.err !== 1'b1 || bus.fill_level !== 6'd32 || bus.bit_pos !== 3'd0) begin
      failures++; $display("FAIL err_len17 actual err=%b fill=%0d pos=%0d required 1/32/0", bus.err, bus.fill_level, bus.bit_pos); end
  endtask

  task automatic test_flush();
    logic [15:0] x;
    do_reset();
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 1, 5, 0, 16'h0);
    cycle(1, 0, 0, 0, 1, 16'hFFFF);
    checks++; if (bus.fill_level !== 6'd0 || bus.bit_pos !== 3'd0 || bus.win_data !== 16'h0 || bus.win_valid !== 1'b0) begin
      failures++; $display("FAIL flush actual fill=%0d pos=%0d win=%h wv=%b required 0/0/0000/0", bus.fill_level, bus.bit_pos, bus.win_data, bus.win_valid); end
    x = 16'($urandom);
    cycle(0, 0, 0, 0, 1, x);
    checks++; if (bus.win_data !== x || bus.fill_level !== 6'd16) begin
      failures++; $display("FAIL flush_refill actual win=%h fill=%0d required %h/16", bus.win_data, bus.fill_level, x); end
    cycle(0, 0, 0, 0, 1, 16'($urandom));
    cycle(0, 0, 0, 0, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.fill_level !== 6'd0 || bus.win_data !== 16'h0 || bus.win_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bit_pos !== 3'd0) begin
      failures++; $display("FAIL async_reset actual fill=%0d win=%h wv=%b rdy=%b pos=%0d", bus.fill_level, bus.win_data, bus.win_valid, bus.in_ready, bus.bit_pos); end
    do_reset();
  endtask

  task automatic test_random();
    bit fl, al, co, v;
    int len;
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) do_reset();
      fl  = ($urandom_range(0, 59) == 0);
      al  = ($urandom_range(0, 9) == 0);
      co  = ($urandom_range(0, 1) == 1);
      len = ($urandom_range(0, 24) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      v   = ($urandom_range(0, 3) != 0);
      cycle(fl, al, co, len, v, 16'($urandom));
      checks++; if (bus.win_data !== m_win()) begin failures++; $display("FAIL rand_win cyc=%0d actual=%h required=%h", c, bus.win_data, m_win()); end
      checks++; if (bus.fill_level !== 6'(mq.size())) begin failures++; $display("FAIL rand_fill cyc=%0d actual=%0d required=%0d", c, bus.fill_level, mq.size()); end
      checks++; if (bus.bit_pos !== 3'(mpos)) begin failures++; $display("FAIL rand_pos cyc=%0d actual=%0d required=%0d", c, bus.bit_pos, mpos); end
      checks++; if (bus.err !== merr) begin failures++; $display("FAIL rand_err cyc=%0d actual=%b required=%b", c, bus.err, merr); end
      checks++; if (bus.in_ready !== (mq.size() <= 32) || bus.win_valid !== (mq.size() >= 16)) begin
        failures++; $display("FAIL rand_flags cyc=%0d actual rdy=%b wv=%b fill_model=%0d", c, bus.in_ready, bus.win_valid, mq.size()); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_push();
    test_consume_align();
    test_full();
    test_back_to_back();
    test_err();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
